mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit for the MIPS core; consumes the A/B operands read out of the register file in the execute stage.
- Iterative radix-2 engine: one bit per cycle for MULT/MULTU/DIV/DIVU.
- Holds the architectural HI/LO registers and services MTHI/MTLO writes.
- Exposes busy so the pipeline stalls MFHI/MFLO and further mul/div issue until the result lands.

Parameters:
- WIDTH, 32, operand width. HI and LO are WIDTH each. Iteration count = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  issue request; sampled only when busy=0
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  operand rs (multiplicand / dividend)
- b  in  WIDTH  operand rt (multiplier / divisor)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; HI/LO just updated by an operation

Behaviour:
- Reset (rst_n=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, internal accumulators=0. Reset mid-operation aborts it; HI/LO read 0 afterwards.
- FSM IDLE -> CALC -> FIX -> IDLE.
  - IDLE: start=1 latches op, a, b and the sign flags. For signed ops it latches magnitudes |a| and |b|. Next state CALC with counter=0.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After step WIDTH-1 the FSM goes to FIX.
  - FIX: applies sign correction, then writes HI/LO. Next state IDLE.
- Timing, with start sampled at edge 0:
  - busy=1 from after edge 0 through edge WIDTH+1 (WIDTH+1 cycles).
  - HI/LO update at edge WIDTH+1.
  - done=1 for exactly the following cycle, with busy=0 in that same cycle.
  - Back-to-back start in the done cycle is accepted.
- Multiply result: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
  - MULT: product negated iff sign(a) XOR sign(b).
- Divide result: LO = quotient, HI = remainder, truncation toward zero.
  - Quotient negated iff sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
- Divide by zero (b=0), DIV and DIVU: LO = all ones, HI = a. Same latency as a normal divide; no exception.
- Signed overflow (DIV, a = most negative, b = -1): LO = a, HI = 0.
- MTHI/MTLO:
  - When busy=0: hi_we writes wdata to hi (lo_we to lo) at the clock edge and is visible the next cycle. Both may be asserted together.
  - When busy=1: ignored; the pipeline guarantees a stall instead.
- start while busy=1: ignored; no state change.
- start and hi_we/lo_we in the same IDLE cycle: start wins; the MT write is dropped, since the pending result overwrites HI/LO anyway.
- done never asserts outside the cycle after FIX. HI/LO hold their value at all other times.

Decomposition:
- Shared package mips_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - the FSM state enum (IDLE, CALC, FIX).
- One sub-module, mdu_iter_core: datapath accumulator plus one-bit step for both mul and div. Control, sign handling and HI/LO stay in mul_div_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle 34 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1-33.
- MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0; then DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- Contention case:
  - Stimulus: DIVU 100/7; second start and hi_we (wdata=0x1234) at cycle 10.
  - Response: both ignored; lo=14, hi=2.
  - Follow-up: MTLO 0xABCD in IDLE -> lo=0xABCD next cycle.
- Reset case:
  - Stimulus: rst_n low for 1 cycle at cycle 15 of a MULTU 7*9.
  - Response: busy=0 and hi=lo=0 immediately; no done pulse.
  - Follow-up: a fresh MULTU 7*9 -> lo=63.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: encodings shared by the MIPS execute-stage units.
// Holds the HI/LO unit op codes and its FSM state constants.
package mips_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: unsigned radix-2 datapath, one bit per step.
// Shift-add for multiply, restoring shift-subtract for divide.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic             div_q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] sub;
    logic             ge;

    // When ge holds, sh-d < d, so the low WIDTH bits are the whole difference.
    always_comb begin
        addend = acc_lo[0] ? d : '0;
        sum    = {1'b0, acc_hi} + {1'b0, addend};
        sh     = {acc_hi, acc_lo[WIDTH-1]};
        ge     = sh >= {1'b0, d};
        sub    = sh[WIDTH-1:0] - d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= 1'b0;
            d      <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (load) begin
            div_q  <= div;
            d      <= div ? b_mag : a_mag;
            acc_hi <= '0;
            acc_lo <= div ? a_mag : b_mag;
        end else if (step) begin
            if (div_q) begin
                acc_hi <= ge ? sub : sh[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ge};
            end else begin
                acc_hi <= sum[WIDTH:1];
                acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide unit with MTHI/MTLO.
// Control, sign handling and the architectural HI/LO live here.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               is_signed;
    logic               sa;
    logic               sb;
    logic               bz;
    logic [WIDTH-1:0]   a_q;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic               load;

    assign busy = state != IDLE;
    assign load = (state == IDLE) && start;

    always_comb begin
        a_neg    = ~op[0] & a[WIDTH-1];
        b_neg    = ~op[0] & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        neg_q    = is_signed & (sa ^ sb);
        neg_r    = is_signed & sa;
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (state == CALC),
        .div    (op[1]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            bz        <= 1'b0;
            a_q       <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        is_div    <= op[1];
                        is_signed <= ~op[0];
                        sa        <= a_neg;
                        sb        <= b_neg;
                        bz        <= b == '0;
                        a_q       <= a;
                        cnt       <= '0;
                        state     <= CALC;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    // Divide by zero returns the raw dividend, not |a|.
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (bz) begin
                        hi <= a_q;
                        lo <= '1;
                    end else begin
                        lo <= neg_q ? -acc_lo : acc_lo;
                        hi <= neg_r ? -acc_hi : acc_hi;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for the HI/LO mul/div unit.
// Driver pushes expected {hi,lo}; a negedge monitor pops on done.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: plain 64-bit arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'b00: return 64'(sx * sy);
            2'b01: return ux * uy;
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sx / sy;
                    r = sx % sy;
                end else begin
                    q = longint'(ux / uy);
                    r = longint'(ux % uy);
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {hi, lo}, 64'hx);
            end else begin
                check("result", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Issue one op and track busy/done timing over its fixed latency.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        logic bad;
        bad = 1'b0;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(model(o, x, y));
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= W + 1; k++) begin
            if (!busy || done) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check("busy_window", {63'b0, bad}, 64'd0);
        check("done_pulse", {62'b0, done, busy}, 64'd2);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          bad;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_ctl", {62'b0, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd100, 32'd0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0);

        // Contention: start and MTHI during busy are ignored.
        op = 2'b11;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        exp_q.push_back(64'h0000_0002_0000_000E);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        op = 2'b01;
        a = 32'd3;
        b = 32'd3;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        bad = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            #1;
        end
        check("contend_done", {63'b0, done}, 64'd1);
        @(posedge clk);
        #1;
        check("contend_idle", {63'b0, busy}, 64'd0);

        lo_we = 1'b1;
        wdata = 32'hABCD;
        @(posedge clk);
        #1 lo_we = 1'b0;
        check("mtlo", {hi, lo}, 64'h0000_0002_0000_ABCD);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi_mtlo", {hi, lo}, 64'h5555_AAAA_5555_AAAA);

        // start wins over a same-cycle MT write.
        op = 2'b01;
        a = 32'd6;
        b = 32'd7;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'hDEAD;
        exp_q.push_back(64'd42);
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        check("start_wins", {32'b0, hi}, 64'h5555_AAAA);
        repeat (W + 2) @(posedge clk);
        #1;

        // Reset mid-operation aborts with no done.
        op = 2'b01;
        a = 32'd7;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_regs", {hi, lo}, 64'd0);
        check("abort_busy", {62'b0, busy, done}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        run_op(2'b01, 32'd7, 32'd9);
        check("after_reset", {hi, lo}, 64'd63);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb);
        end

        @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
